// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - multi-cycle restoring divider for MIPS DIV/DIVU
//
// Produces one quotient bit per clock by trial subtraction. It takes WIDTH
// BUSY cycles per operation. The quotient goes to LO and the remainder to HI.
//
// Optional feature macro: SIGNED_DIV_EN
//   defined   : is_signed=1 divides the operand magnitudes. The final step then
//               fixes the signs: the quotient truncates toward zero and the
//               remainder takes the sign of the dividend.
//   undefined : is_signed is ignored and every operation is unsigned.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request, accepted on a rising edge while ready=1
//   is_signed    1 = DIV, 0 = DIVU (only with SIGNED_DIV_EN)
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   ready        high in IDLE and DONE
//   done         one-cycle pulse, results valid
//   quotient     LO result, held until the next final step
//   remainder    HI result, held until the next final step
//   div_by_zero  captured divisor was zero, held like the results

module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] qr;       // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dmag;     // divisor magnitude
  logic             zero;     // captured divisor was zero
  logic             neg_q;    // negate the quotient in the final step
  logic             neg_r;    // negate the remainder in the final step

  logic             sgn;
  logic             dd_neg, dv_neg;
  logic [WIDTH-1:0] dd_mag, dv_mag;
  logic             last;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nx, q_nx, q_fix, r_fix;

`ifdef SIGNED_DIV_EN
  assign sgn = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sgn = 1'b0;
`endif

  assign dd_neg = sgn & dividend[WIDTH-1];
  assign dv_neg = sgn & divisor[WIDTH-1];
  assign dd_mag = dd_neg ? (~dividend + 1'b1) : dividend;
  assign dv_mag = dv_neg ? (~divisor + 1'b1) : divisor;

  assign last  = (count == CW'(WIDTH - 1));
  assign ready = (state != S_BUSY);
  assign done  = (state == S_DONE);

  // One restoring step. The shifted remainder keeps its top bit so that
  // divisors near 2^WIDTH cannot lose a bit.
  always_comb begin
    shifted = {rem, qr[WIDTH-1]};
    trial   = shifted - {1'b0, dmag};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      q_nx   = {qr[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      q_nx   = {qr[WIDTH-2:0], 1'b0};
    end
    // A zero divisor never borrows, so the remainder already equals |dividend|.
    // Only the quotient needs forcing to all ones.
    q_fix = zero ? {WIDTH{1'b1}} : (neg_q ? (~q_nx + 1'b1) : q_nx);
    r_fix = neg_r ? (~rem_nx + 1'b1) : rem_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      rem         <= '0;
      qr          <= '0;
      dmag        <= '0;
      zero        <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_BUSY;
            count <= '0;
            rem   <= '0;
            qr    <= dd_mag;
            dmag  <= dv_mag;
            zero  <= (divisor == '0);
            neg_q <= dd_neg ^ dv_neg;
            neg_r <= dd_neg;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          rem   <= rem_nx;
          qr    <= q_nx;
          count <= count + 1'b1;
          if (last) begin
            state       <= S_DONE;
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= zero;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// tb/tb_seq_divider32.sv - scoreboard bench for seq_divider32

module tb_seq_divider32;

  localparam int W = 32;
`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider32 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .ready(ready), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg);
    res_t e;
    logic sg_eff;
    sg_eff = sg & SIGNED_EN;
    if (dv == '0) begin
      e.q = '1; e.r = dd; e.z = 1'b1;
    end else if (sg_eff) begin
      e.z = 1'b0;
      if (dd == {1'b1, {(W-1){1'b0}}} && dv == '1) begin
        e.q = dd; e.r = '0;
      end else begin
        e.q = $signed(dd) / $signed(dv);
        e.r = $signed(dd) % $signed(dv);
      end
    end else begin
      e.z = 1'b0; e.q = dd / dv; e.r = dd % dv;
    end
    return e;
  endfunction

  // Drive one request for one accepting edge; called #1 after an edge.
  task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg, input res_t e);
    dividend = dd; divisor = dv; is_signed = sg; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from now until done is seen, bounded at 60.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q got %h exp 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r got %h exp 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", div_by_zero); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int c;
    res_t e;
    logic [W-1:0] dd, dv;
    issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, z: 1'b0});
    wait_done(c);
    e = exp_q.pop_front();
    checks++; if (c !== 32) begin errors++; $display("FAIL u100_latency got %0d exp 32", c); end
    checks++; if (quotient !== e.q) begin errors++; $display("FAIL u100_q got %h exp %h", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("FAIL u100_r got %h exp %h", remainder, e.r); end
    checks++; if (div_by_zero !== e.z) begin errors++; $display("FAIL u100_dz got %b exp %b", div_by_zero, e.z); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL q_hold got %h exp 0000000e", quotient); end
    for (int i = 0; i < 8; i++) begin
      dd = $urandom;
      case (i % 4)
        0: dv = $urandom_range(1, 255);
        1: dv = $urandom;
        2: dv = dd;
        default: dv = 32'hFFFFFFFE;
      endcase
      if (i == 7) dd = 32'hFFFFFFFF;
      issue(dd, dv, 1'b0, model(dd, dv, 1'b0));
      wait_done(c);
      e = exp_q.pop_front();
      checks++; if (c !== 32) begin errors++; $display("FAIL rnd_latency got %0d exp 32", c); end
      checks++; if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z})
        begin errors++; $display("FAIL rnd_result %h/%h got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                                 dd, dv, quotient, remainder, div_by_zero, e.q, e.r, e.z); end
    end
  endtask

  task automatic test_div_zero;
    int c;
    res_t e;
    issue(32'h1234, 32'h0, 1'b0, '{q: 32'hFFFFFFFF, r: 32'h1234, z: 1'b1});
    wait_done(c);
    e = exp_q.pop_front();
    checks++; if (c !== 32) begin errors++; $display("FAIL dz_latency got %0d exp 32", c); end
    checks++; if (quotient !== e.q) begin errors++; $display("FAIL dz_q got %h exp %h", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("FAIL dz_r got %h exp %h", remainder, e.r); end
    checks++; if (div_by_zero !== e.z) begin errors++; $display("FAIL dz_flag got %b exp %b", div_by_zero, e.z); end
  endtask

  task automatic test_back_to_back;
    int c;
    res_t e;
    issue(32'd1000, 32'd3, 1'b0, '{q: 32'd333, r: 32'd1, z: 1'b0});
    wait_done(c);
    e = exp_q.pop_front();
    checks++; if ({quotient, remainder} !== {e.q, e.r})
      begin errors++; $display("FAIL b2b_first got q=%h r=%h exp q=%h r=%h", quotient, remainder, e.q, e.r); end
    // Still in the DONE cycle: this start must be taken on the next edge.
    issue(32'hFFFFFFFF, 32'd1, 1'b0, '{q: 32'hFFFFFFFF, r: 32'd0, z: 1'b0});
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready=%b exp 0", ready); end
    wait_done(c);
    e = exp_q.pop_front();
    checks++; if (c + 1 !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", c + 1); end
    checks++; if (quotient !== e.q) begin errors++; $display("FAIL b2b_q got %h exp %h", quotient, e.q); end
    checks++; if (remainder !== e.r) begin errors++; $display("FAIL b2b_r got %h exp %h", remainder, e.r); end
  endtask

  task automatic test_busy_start;
    int ndone, first;
    res_t e;
    ndone = 0; first = 0;
    issue(32'd500, 32'd9, 1'b0, '{q: 32'd55, r: 32'd5, z: 1'b0});
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 5) begin dividend = 32'd77; divisor = 32'd0; start = 1'b1; end
      if (cyc == 6) begin
        start = 1'b0;
        checks++; if (quotient !== 32'hFFFFFFFF)
          begin errors++; $display("FAIL busy_prior_q got %h exp ffffffff", quotient); end
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first == 0) first = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL busy_extra_done got 1 exp 0");
        end else begin
          e = exp_q.pop_front();
          checks++; if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z})
            begin errors++; $display("FAIL busy_result got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                                     quotient, remainder, div_by_zero, e.q, e.r, e.z); end
        end
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", ndone); end
    checks++; if (first !== 32) begin errors++; $display("FAIL busy_latency got %0d exp 32", first); end
  endtask

  task automatic test_signed;
    logic [W-1:0] dds[5];
    logic [W-1:0] dvs[5];
    int c;
    res_t e;
    dds = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'hFFFFFFF9, 32'h80000000};
    dvs = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd3};
    for (int i = 0; i < 5; i++) begin
      issue(dds[i], dvs[i], 1'b1, model(dds[i], dvs[i], 1'b1));
      wait_done(c);
      e = exp_q.pop_front();
      checks++; if (c !== 32) begin errors++; $display("FAIL sgn_latency got %0d exp 32", c); end
      checks++; if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z})
        begin errors++; $display("FAIL sgn_result %h/%h got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                                 dds[i], dvs[i], quotient, remainder, div_by_zero, e.q, e.r, e.z); end
      if (i == 0) begin
        // -7/2: (-3, -1) when signed, (0x7FFFFFFC, 1) when unsigned.
        checks++; if (quotient !== (SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC))
          begin errors++; $display("FAIL sgn_m7_q got %h", quotient); end
        checks++; if (remainder !== (SIGNED_EN ? 32'hFFFFFFFF : 32'd1))
          begin errors++; $display("FAIL sgn_m7_r got %h", remainder); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, z: 1'b0});
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b exp 0", done); end
    checks++; if ({quotient, remainder} !== '0)
      begin errors++; $display("FAIL mid_rst_results got q=%h r=%h exp 0", quotient, remainder); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_rst_no_done got %0d exp 0", ndone); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_unsigned;
    test_div_zero;
    test_back_to_back;
    test_busy_start;
    test_signed;
    test_reset_mid;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
